// File: rtl/ili9341_spi_responder.sv
// ILI9341 4-wire serial receiver: oversampled front end, byte assembly, and
// CASET/PASET/RAMWR decode producing addressed RGB565 pixel strobes.
module ili9341_spi_responder #(
    parameter int MAX_X       = 239,
    parameter int MAX_Y       = 319,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,        // active-low, asynchronous
    input  logic        sck_i,
    input  logic        cs_i,
    input  logic        dc_i,
    input  logic        din_i,
    output logic        cmd_valid_o,
    output logic [7:0]  cmd_byte_o,
    output logic        pixel_valid_o,
    output logic [15:0] pixel_data_o,
    output logic [8:0]  pixel_x_o,
    output logic [8:0]  pixel_y_o,
    output logic        frame_done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {ST_NONE, ST_CASET, ST_PASET, ST_RAMWR, ST_OTHER} state_t;

    localparam logic [8:0]  MAX_X9  = 9'(MAX_X);
    localparam logic [8:0]  MAX_Y9  = 9'(MAX_Y);
    localparam logic [15:0] MAX_X16 = 16'(MAX_X);
    localparam logic [15:0] MAX_Y16 = 16'(MAX_Y);

    // ---------------- front end ----------------
    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, dc_sync_q, din_sync_q;
    logic sck_prev_q, cs_prev_q;
    logic sck_s, cs_s, dc_s, din_s, sck_rise, cs_rise;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign dc_s     = dc_sync_q[SYNC_STAGES-1];
    assign din_s    = din_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q & ~cs_s;
    assign cs_rise  = cs_s & ~cs_prev_q;

    // Synchronise the serial pins; cs idles high so reset release is not a deassert.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sck_sync_q <= '0;
            cs_sync_q  <= '1;
            dc_sync_q  <= '0;
            din_sync_q <= '0;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
            dc_sync_q  <= {dc_sync_q[SYNC_STAGES-2:0], dc_i};
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din_i};
            sck_prev_q <= sck_s;
            cs_prev_q  <= cs_s;
        end
    end

    logic [6:0] shreg_q;
    logic [2:0] bit_cnt_q;
    logic       byte_vld_q, byte_dc_q, abort_q;
    logic [7:0] byte_q;

    // Assemble bytes MSB first; a cs deassert mid-byte throws the partial byte away.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            byte_vld_q <= 1'b0;
            byte_dc_q  <= 1'b0;
            byte_q     <= '0;
            abort_q    <= 1'b0;
        end else begin
            byte_vld_q <= 1'b0;
            abort_q    <= 1'b0;
            if (sck_rise) begin
                shreg_q <= {shreg_q[5:0], din_s};
                if (bit_cnt_q == 3'd7) begin
                    byte_vld_q <= 1'b1;
                    byte_q     <= {shreg_q, din_s};
                    byte_dc_q  <= dc_s;
                    bit_cnt_q  <= '0;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
            end else if (cs_rise && bit_cnt_q != 3'd0) begin
                bit_cnt_q <= '0;
                abort_q   <= 1'b1;
            end
        end
    end

    // ---------------- decode ----------------
    state_t      state_q, state_d;
    logic [2:0]  param_cnt_q, param_cnt_d;
    logic [23:0] stage_q, stage_d;
    logic [8:0]  x_start_q, x_start_d, x_end_q, x_end_d;
    logic [8:0]  y_start_q, y_start_d, y_end_q, y_end_d;
    logic [8:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic        byte_phase_q, byte_phase_d;
    logic [7:0]  hi_q, hi_d;
    logic        cmd_valid_q, cmd_valid_d, pixel_valid_q, pixel_valid_d;
    logic        frame_done_q, frame_done_d, err_q, err_d;
    logic [7:0]  cmd_byte_q, cmd_byte_d;
    logic [15:0] pixel_data_q, pixel_data_d;
    logic [8:0]  pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
    logic [15:0] p_start, p_end, p_lim;

    // The 4th parameter byte completes end[7:0]; the rest sits in staging.
    assign p_start = stage_q[23:8];
    assign p_end   = {stage_q[7:0], byte_q};
    assign p_lim   = (state_q == ST_CASET) ? MAX_X16 : MAX_Y16;

    // Register all decode state and outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= ST_NONE;
            param_cnt_q   <= '0;
            stage_q       <= '0;
            x_start_q     <= '0;
            x_end_q       <= MAX_X9;
            y_start_q     <= '0;
            y_end_q       <= MAX_Y9;
            cur_x_q       <= '0;
            cur_y_q       <= '0;
            byte_phase_q  <= 1'b0;
            hi_q          <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_byte_q    <= '0;
            pixel_valid_q <= 1'b0;
            pixel_data_q  <= '0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            param_cnt_q   <= param_cnt_d;
            stage_q       <= stage_d;
            x_start_q     <= x_start_d;
            x_end_q       <= x_end_d;
            y_start_q     <= y_start_d;
            y_end_q       <= y_end_d;
            cur_x_q       <= cur_x_d;
            cur_y_q       <= cur_y_d;
            byte_phase_q  <= byte_phase_d;
            hi_q          <= hi_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_byte_q    <= cmd_byte_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_data_q  <= pixel_data_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            frame_done_q  <= frame_done_d;
            err_q         <= err_d;
        end
    end

    // Command state machine: command bytes select state, data bytes act per state.
    always_comb begin
        state_d       = state_q;
        param_cnt_d   = param_cnt_q;
        stage_d       = stage_q;
        x_start_d     = x_start_q;
        x_end_d       = x_end_q;
        y_start_d     = y_start_q;
        y_end_d       = y_end_q;
        cur_x_d       = cur_x_q;
        cur_y_d       = cur_y_q;
        byte_phase_d  = byte_phase_q;
        hi_d          = hi_q;
        cmd_byte_d    = cmd_byte_q;
        pixel_data_d  = pixel_data_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        cmd_valid_d   = 1'b0;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        err_d         = abort_q;
        if (byte_vld_q) begin
            if (!byte_dc_q) begin
                cmd_byte_d   = byte_q;
                cmd_valid_d  = 1'b1;
                param_cnt_d  = '0;
                byte_phase_d = 1'b0;
                case (byte_q)
                    8'h2A:   state_d = ST_CASET;
                    8'h2B:   state_d = ST_PASET;
                    8'h2C: begin
                        state_d = ST_RAMWR;
                        cur_x_d = x_start_q;
                        cur_y_d = y_start_q;
                    end
                    default: state_d = ST_OTHER;
                endcase
            end else begin
                case (state_q)
                    ST_CASET, ST_PASET: begin
                        if (param_cnt_q < 3'd3) begin
                            stage_d     = {stage_q[15:0], byte_q};
                            param_cnt_d = param_cnt_q + 3'd1;
                        end else if (param_cnt_q == 3'd3) begin
                            param_cnt_d = 3'd4;
                            if (p_start <= p_end && p_end <= p_lim) begin
                                if (state_q == ST_CASET) begin
                                    x_start_d = p_start[8:0];
                                    x_end_d   = p_end[8:0];
                                end else begin
                                    y_start_d = p_start[8:0];
                                    y_end_d   = p_end[8:0];
                                end
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end
                    ST_RAMWR: begin
                        if (!byte_phase_q) begin
                            hi_d         = byte_q;
                            byte_phase_d = 1'b1;
                        end else begin
                            byte_phase_d  = 1'b0;
                            pixel_valid_d = 1'b1;
                            pixel_data_d  = {hi_q, byte_q};
                            pixel_x_d     = cur_x_q;
                            pixel_y_d     = cur_y_q;
                            if (cur_x_q == x_end_q) begin
                                cur_x_d = x_start_q;
                                if (cur_y_q == y_end_q) begin
                                    cur_y_d      = y_start_q;
                                    frame_done_d = 1'b1;
                                end else begin
                                    cur_y_d = cur_y_q + 9'd1;
                                end
                            end else begin
                                cur_x_d = cur_x_q + 9'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cmd_valid_o   = cmd_valid_q;
    assign cmd_byte_o    = cmd_byte_q;
    assign pixel_valid_o = pixel_valid_q;
    assign pixel_data_o  = pixel_data_q;
    assign pixel_x_o     = pixel_x_q;
    assign pixel_y_o     = pixel_y_q;
    assign frame_done_o  = frame_done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_ili9341_spi_responder.sv
// Directed bench for ili9341_spi_responder: drives the serial link and
// checks logged command/pixel/error strobes against hand-computed values.
module tb_ili9341_spi_responder;

    logic        clk, rst, sck, cs, dc, din;
    logic        cmd_valid, pixel_valid, frame_done, err;
    logic [7:0]  cmd_byte;
    logic [15:0] pixel_data;
    logic [8:0]  pixel_x, pixel_y;

    int n_asrt = 0;
    int n_fail = 0;
    int n_err  = 0;
    int n_fd   = 0;
    logic [8:0]  px_q[$];
    logic [8:0]  py_q[$];
    logic [15:0] pd_q[$];
    logic        pf_q[$];
    logic [7:0]  cmd_q[$];

    ili9341_spi_responder dut (
        .clk_i(clk), .rst_i(rst), .sck_i(sck), .cs_i(cs), .dc_i(dc), .din_i(din),
        .cmd_valid_o(cmd_valid), .cmd_byte_o(cmd_byte),
        .pixel_valid_o(pixel_valid), .pixel_data_o(pixel_data),
        .pixel_x_o(pixel_x), .pixel_y_o(pixel_y),
        .frame_done_o(frame_done), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every strobe away from the active edge.
    always @(negedge clk) begin
        if (pixel_valid) begin
            px_q.push_back(pixel_x);
            py_q.push_back(pixel_y);
            pd_q.push_back(pixel_data);
            pf_q.push_back(frame_done);
        end
        if (cmd_valid) cmd_q.push_back(cmd_byte);
        if (err) n_err++;
        if (frame_done) n_fd++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic d, input logic [7:0] b, input int n);
        cs = 1'b0;
        dc = d;
        for (int i = 0; i < n; i++) begin
            din = b[7-i];
            repeat (4) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic send_byte(input logic d, input logic [7:0] b);
        send_bits(d, b, 8);
    endtask

    task automatic send_cmd4(input logic [7:0] c, input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] p3);
        send_byte(1'b0, c);
        send_byte(1'b1, p0);
        send_byte(1'b1, p1);
        send_byte(1'b1, p2);
        send_byte(1'b1, p3);
    endtask

    task automatic send_pix(input logic [15:0] p);
        send_byte(1'b1, p[15:8]);
        send_byte(1'b1, p[7:0]);
    endtask

    task automatic flush();
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base, bad, e0, np;
        rst = 1'b0; sck = 1'b0; cs = 1'b1; dc = 1'b0; din = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {cmd_valid, cmd_byte, pixel_valid, pixel_data, pixel_x, pixel_y,
                              frame_done, err}, 64'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Window setup
        send_cmd4(8'h2A, 8'h00, 8'h14, 8'h00, 8'hDB);
        send_cmd4(8'h2B, 8'h00, 8'h3C, 8'h01, 8'h03);
        flush();
        chk("setup_err", n_err, 0);
        chk("setup_cmd_cnt", cmd_q.size(), 2);
        chk("setup_cmd0", cmd_q[0], 8'h2A);
        chk("setup_cmd1", cmd_q[1], 8'h2B);

        // 201 pixels across a 200-wide window
        base = px_q.size();
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 201; i++) send_pix(16'hF800);
        flush();
        chk("ramwr_count", px_q.size() - base, 201);
        bad = 0;
        for (int i = 0; i < 200; i++)
            if (px_q[base+i] !== 9'(20 + i) || py_q[base+i] !== 9'd60 || pd_q[base+i] !== 16'hF800)
                bad++;
        chk("ramwr_row_seq", bad, 0);
        chk("ramwr_wrap_addr", {px_q[base+200], py_q[base+200]}, {9'd20, 9'd61});
        chk("ramwr_no_frame_done", n_fd, 0);

        // 2x2 window, frame wrap
        send_cmd4(8'h2A, 8'h00, 8'h00, 8'h00, 8'h01);
        send_cmd4(8'h2B, 8'h00, 8'h00, 8'h00, 8'h01);
        base = px_q.size();
        send_byte(1'b0, 8'h2C);
        for (int i = 1; i <= 5; i++) send_pix(16'(i));
        flush();
        chk("win2_p0", {px_q[base+0], py_q[base+0], pd_q[base+0]}, {9'd0, 9'd0, 16'd1});
        chk("win2_p1", {px_q[base+1], py_q[base+1], pd_q[base+1]}, {9'd1, 9'd0, 16'd2});
        chk("win2_p2", {px_q[base+2], py_q[base+2], pd_q[base+2]}, {9'd0, 9'd1, 16'd3});
        chk("win2_p3", {px_q[base+3], py_q[base+3], pd_q[base+3]}, {9'd1, 9'd1, 16'd4});
        chk("win2_p4", {px_q[base+4], py_q[base+4], pd_q[base+4]}, {9'd0, 9'd0, 16'd5});
        chk("win2_frame_done", {pf_q[base+0], pf_q[base+1], pf_q[base+2], pf_q[base+3], pf_q[base+4]},
            5'b00010);
        chk("win2_fd_total", n_fd, 1);

        // Illegal CASET windows from reset
        do_reset();
        e0 = n_err;
        send_cmd4(8'h2A, 8'h00, 8'h10, 8'h00, 8'h05);
        flush();
        chk("caset_start_gt_end_err", n_err - e0, 1);
        send_cmd4(8'h2A, 8'h00, 8'h00, 8'h01, 8'h00);
        flush();
        chk("caset_end_gt_max_err", n_err - e0, 2);
        base = px_q.size();
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 7; i++) send_pix(16'hAAAA);
        flush();
        chk("bad_caset_first_x", {px_q[base], py_q[base]}, {9'd0, 9'd0});
        chk("bad_caset_seventh_x", {px_q[base+6], py_q[base+6]}, {9'd6, 9'd0});

        // cs abort mid data byte; next pixel takes the same address (7,0)
        e0 = n_err;
        np = px_q.size();
        send_bits(1'b1, 8'h07, 5);
        cs = 1'b1;
        flush();
        chk("abort_err", n_err - e0, 1);
        chk("abort_no_pixel", px_q.size(), np);
        send_pix(16'h07E0);
        flush();
        chk("abort_next_pixel", {px_q[np], py_q[np], pd_q[np]}, {9'd7, 9'd0, 16'h07E0});

        // Async reset mid-RAMWR
        send_cmd4(8'h2A, 8'h00, 8'h05, 8'h00, 8'h09);
        base = px_q.size();
        send_byte(1'b0, 8'h2C);
        send_pix(16'h1234);
        flush();
        chk("pre_reset_pixel", {px_q[base], py_q[base], pd_q[base]}, {9'd5, 9'd0, 16'h1234});
        send_byte(1'b1, 8'h56);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_outputs", {cmd_valid, cmd_byte, pixel_valid, pixel_data, pixel_x, pixel_y,
                                    frame_done, err}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        np = px_q.size();
        send_pix(16'hABCD);
        flush();
        chk("post_reset_no_pixel", px_q.size(), np);
        send_byte(1'b0, 8'h2C);
        send_pix(16'h0001);
        flush();
        chk("post_reset_window", {px_q[np], py_q[np], pd_q[np]}, {9'd0, 9'd0, 16'h0001});

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
